// File: rtl/btn_pkg.sv
// Shared types and width helpers for the multi-channel button front end.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } btn_state_e;

    function automatic int hold_width(int long_ticks, int repeat_ticks);
        return $clog2(((long_ticks > repeat_ticks) ? long_ticks : repeat_ticks) + 1);
    endfunction

    function automatic int presc_width(int cycle);
        return $clog2(cycle);
    endfunction

endpackage

// File: rtl/btn_ch.sv
// One button channel: 2-FF synchroniser, tick-sampled debounce, hold FSM
// producing registered press/release/long/repeat pulses.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | not pressed, waiting for a debounced press
//   PRESSED | pressed, counting ticks towards the long-press threshold
//   HELD    | long press reported, counting ticks between repeat pulses
module btn_ch
    import btn_pkg::*;
#(
    parameter int ACTIVE_LOW   = 1,
    parameter int STABLE_CNT   = 2,
    parameter int LONG_TICKS   = 40,
    parameter int REPEAT_TICKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int   HW       = hold_width(LONG_TICKS, REPEAT_TICKS);
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

    logic          sync1, sync2, s;
    logic [3:0]    st;
    logic          change, rise, fall;
    btn_state_e    state, state_nx;
    logic [HW-1:0] hold, hold_nx, hold_inc;
    logic          long_nx, rpt_nx;

    assign s      = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign change = tick && (s != level) && (st == 4'(STABLE_CNT - 1));
    assign rise   = change && s;
    assign fall   = change && !s;

    // Sync FFs reset to the idle pin value so the normalised input reads released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1         <= IDLE_PIN;
            sync2         <= IDLE_PIN;
            st            <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= pin;
            sync2         <= sync1;
            press         <= rise;
            release_pulse <= fall;
            if (tick) begin
                if (s == level) begin
                    st <= '0;
                end else if (change) begin
                    level <= s;
                    st    <= '0;
                end else begin
                    st <= st + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold         <= '0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_nx;
            hold         <= hold_nx;
            long_press   <= long_nx;
            repeat_pulse <= rpt_nx;
        end
    end

    // Release wins over long/repeat on the same tick.
    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        long_nx  = 1'b0;
        rpt_nx   = 1'b0;
        hold_inc = (hold == '1) ? hold : hold + HW'(1);
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = PRESSED;
                    hold_nx  = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_nx = IDLE;
                    hold_nx  = '0;
                end else if (tick && level) begin
                    if (hold_inc == HW'(LONG_TICKS)) begin
                        long_nx  = 1'b1;
                        state_nx = HELD;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_inc;
                    end
                end
            end
            HELD: begin
                if (fall) begin
                    state_nx = IDLE;
                    hold_nx  = '0;
                end else if (tick) begin
                    if ((REPEAT_TICKS != 0) && (hold_inc == HW'(REPEAT_TICKS))) begin
                        rpt_nx  = 1'b1;
                        hold_nx = '0;
                    end else begin
                        hold_nx = hold_inc;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                hold_nx  = '0;
            end
        endcase
    end

endmodule

// File: rtl/btn_in_multi.sv
// N_CH debounced button inputs sharing one sample-tick prescaler.
module btn_in_multi
    import btn_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int CYCLE        = 1250000,
    parameter int ACTIVE_LOW   = 1,
    parameter int STABLE_CNT   = 2,
    parameter int LONG_TICKS   = 40,
    parameter int REPEAT_TICKS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_pulse
);

    localparam int PW = presc_width(CYCLE);

    logic [PW-1:0] cnt;
    logic          tick;

    assign tick = (cnt == PW'(CYCLE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + PW'(1);
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_ch #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .STABLE_CNT  (STABLE_CNT),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .pin          (btn[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .long_press   (long_press[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_in_multi.sv
// Scoreboard bench: stimulus pushes expected pulse events, a negedge monitor pops and compares.
module tb_btn_in_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_lo, btn_hi;
    logic [2:0] lvl_lo, prs_lo, rel_lo, lng_lo, rpt_lo;
    logic [2:0] lvl_hi, prs_hi, rel_hi, lng_hi, rpt_hi;

    typedef struct {
        int          tick;
        logic [14:0] vec;
    } exp_t;

    exp_t q_lo[$];
    exp_t q_hi[$];
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    btn_in_multi #(.N_CH(3), .CYCLE(10), .ACTIVE_LOW(1), .STABLE_CNT(2),
                   .LONG_TICKS(5), .REPEAT_TICKS(3)) dut_lo (
        .clk(clk), .rst(rst), .btn(btn_lo), .level(lvl_lo), .press(prs_lo),
        .release_pulse(rel_lo), .long_press(lng_lo), .repeat_pulse(rpt_lo));

    btn_in_multi #(.N_CH(3), .CYCLE(10), .ACTIVE_LOW(0), .STABLE_CNT(2),
                   .LONG_TICKS(5), .REPEAT_TICKS(3)) dut_hi (
        .clk(clk), .rst(rst), .btn(btn_hi), .level(lvl_hi), .press(prs_hi),
        .release_pulse(rel_hi), .long_press(lng_hi), .repeat_pulse(rpt_hi));

    // Bench-side cycle count since reset release; tick k output is visible at cyc == 10*k.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [14:0] mk(logic [2:0] l, logic [2:0] p, logic [2:0] r,
                                       logic [2:0] lg, logic [2:0] rp);
        return {l, p, r, lg, rp};
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, id, cyc, act, exp);
    endtask

    task automatic mon(input int id, input logic [14:0] v);
        exp_t e;
        if (v[11:0] == 12'h0) return;
        if ((id == 0 && q_lo.size() == 0) || (id == 1 && q_hi.size() == 0)) begin
            n_checks++;
            $display("FAIL unexpected_pulse dut%0d cyc=%0d got=%h expected=none", id, cyc, v);
            return;
        end
        if (id == 0) e = q_lo.pop_front();
        else         e = q_hi.pop_front();
        chk("event_time", id, 32'(cyc), 32'(e.tick * 10));
        chk("event_outputs", id, {17'h0, v}, {17'h0, e.vec});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, {lvl_lo, prs_lo, rel_lo, lng_lo, rpt_lo});
            mon(1, {lvl_hi, prs_hi, rel_hi, lng_hi, rpt_hi});
        end
    end

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_lo(input int t, input logic [14:0] v);
        exp_t e;
        e.tick = t; e.vec = v;
        q_lo.push_back(e);
    endtask

    task automatic push_hi(input int t, input logic [14:0] v);
        exp_t e;
        e.tick = t; e.vec = v;
        q_hi.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        btn_lo = 3'b111;
        btn_hi = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Epoch 1: drive ch1 into HELD, then reset in the middle of it.
        at_cyc(2);   btn_lo[1] = 1'b0;
        push_lo(2,  mk(3'b010, 3'b010, 3'b000, 3'b000, 3'b000));
        push_lo(7,  mk(3'b010, 3'b000, 3'b000, 3'b010, 3'b000));
        push_lo(10, mk(3'b010, 3'b000, 3'b000, 3'b000, 3'b010));
        at_cyc(105);
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs_lo", 0, {17'h0, lvl_lo, prs_lo, rel_lo, lng_lo, rpt_lo}, 32'h0);
        chk("reset_outputs_hi", 1, {17'h0, lvl_hi, prs_hi, rel_hi, lng_hi, rpt_hi}, 32'h0);
        chk("queue_empty_epoch1", 0, 32'(q_lo.size()), 32'h0);
        btn_lo = 3'b111;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single press/release on ch0.
        at_cyc(2);   btn_lo[0] = 1'b0;
        push_lo(2,  mk(3'b001, 3'b001, 3'b000, 3'b000, 3'b000));
        at_cyc(32);  btn_lo[0] = 1'b1;
        push_lo(5,  mk(3'b000, 3'b000, 3'b001, 3'b000, 3'b000));

        // Bounce on ch0 alternating at tick rate, then settle pressed.
        for (int k = 0; k < 6; k++) begin
            at_cyc(62 + 10 * k); btn_lo[0] = k[0];
        end
        at_cyc(122); btn_lo[0] = 1'b0;
        push_lo(14, mk(3'b001, 3'b001, 3'b000, 3'b000, 3'b000));
        push_lo(19, mk(3'b001, 3'b000, 3'b000, 3'b001, 3'b000));
        for (int k = 0; k < 4; k++) begin
            at_cyc(152 + 10 * k); btn_lo[0] = ~k[0];
        end
        at_cyc(192); btn_lo[0] = 1'b1;
        push_lo(21, mk(3'b000, 3'b000, 3'b001, 3'b000, 3'b000));

        // Long hold on ch2; release lands on what would be a repeat tick.
        at_cyc(222); btn_lo[2] = 1'b0;
        push_lo(24, mk(3'b100, 3'b100, 3'b000, 3'b000, 3'b000));
        push_lo(29, mk(3'b100, 3'b000, 3'b000, 3'b100, 3'b000));
        push_lo(32, mk(3'b100, 3'b000, 3'b000, 3'b000, 3'b100));
        push_lo(35, mk(3'b100, 3'b000, 3'b000, 3'b000, 3'b100));

        // Active-high instance: two channels together.
        at_cyc(302); btn_hi = 3'b101;
        push_hi(32, mk(3'b101, 3'b101, 3'b000, 3'b000, 3'b000));
        at_cyc(332); btn_hi = 3'b000;
        push_hi(35, mk(3'b000, 3'b000, 3'b101, 3'b000, 3'b000));

        at_cyc(362); btn_lo[2] = 1'b1;
        push_lo(38, mk(3'b000, 3'b000, 3'b100, 3'b000, 3'b000));

        // Short hold on ch1, then release exactly on the long threshold tick.
        at_cyc(392); btn_lo[1] = 1'b0;
        push_lo(41, mk(3'b010, 3'b010, 3'b000, 3'b000, 3'b000));
        at_cyc(422); btn_lo[1] = 1'b1;
        push_lo(44, mk(3'b000, 3'b000, 3'b010, 3'b000, 3'b000));
        at_cyc(452); btn_lo[1] = 1'b0;
        push_lo(47, mk(3'b010, 3'b010, 3'b000, 3'b000, 3'b000));
        at_cyc(502); btn_lo[1] = 1'b1;
        push_lo(52, mk(3'b000, 3'b000, 3'b010, 3'b000, 3'b000));

        at_cyc(600);
        chk("queue_empty_lo", 0, 32'(q_lo.size()), 32'h0);
        chk("queue_empty_hi", 1, 32'(q_hi.size()), 32'h0);
        chk("final_level_lo", 0, {29'h0, lvl_lo}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
